// File: rtl/vend_pkg.sv
// Shared state encoding, widths and small helpers for the coffee vending controller.
package vend_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CREDIT = 2'd1;
  localparam logic [1:0] VEND   = 2'd2;
  localparam logic [1:0] CHANGE = 2'd3;

  localparam int UNIT_VALUE = 50;
  localparam int CREDIT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_CREDIT = CREDIT,
    ST_VEND   = VEND,
    ST_CHANGE = CHANGE
  } state_t;

  // Units added by one cycle of coin pulses; both together count as 3.
  function automatic logic [1:0] coin_units(input logic c50, input logic c100);
    return {c100, 1'b0} + {1'b0, c50};
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter; expire is high during the last counted cycle.
module vend_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (clear) begin
      count <= '0;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == W'(1));

endmodule

// File: rtl/vend_controller.sv
// Coin credit / vend / change sequencing controller with registered outputs.
// Define VEND_IDLE_TIMEOUT_EN to refund credit after IDLE_TIMEOUT idle cycles in CREDIT.
module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE_UNITS  = 6,
  parameter int MAX_UNITS    = 15,
  parameter int DISP_TIMEOUT = 1000,
  parameter int IDLE_TIMEOUT = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin50,
  input  logic                coin100,
  input  logic                cancel,
  input  logic                disp_ack,
  output logic                disp_req,
  output logic                change50,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                fault
);

  // Timer is sized for whichever timeout is longer since both share it.
  localparam int TIMER_W = $clog2(max_int(DISP_TIMEOUT, IDLE_TIMEOUT) + 1);

  typedef logic [CREDIT_W:0] sum_t;
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE_UNITS);
  localparam sum_t                MAX_C   = sum_t'(MAX_UNITS);

  state_t              state, state_nxt;
  logic [CREDIT_W-1:0] credit_nxt, cr_acc;
  sum_t                sum;
  logic [1:0]          add;
  logic                coin_in, open_st, accept;
  logic                disp_req_nxt, change50_nxt, coin_reject_nxt, busy_nxt, fault_nxt;
  logic                t_load, t_clear, timer_expire;
  logic [TIMER_W-1:0]  t_val;

  vend_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .clear    (t_clear),
    .load_val (t_val),
    .expire   (timer_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      credit      <= '0;
      disp_req    <= 1'b0;
      change50    <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      disp_req    <= disp_req_nxt;
      change50    <= change50_nxt;
      coin_reject <= coin_reject_nxt;
      busy        <= busy_nxt;
      fault       <= fault_nxt;
    end
  end

  always_comb begin
    add     = coin_units(coin50, coin100);
    sum     = sum_t'(credit) + sum_t'(add);
    coin_in = (add != 2'd0);
    open_st = (state == ST_IDLE) || (state == ST_CREDIT);
    accept  = coin_in && open_st && (sum <= MAX_C);
    cr_acc  = accept ? sum[CREDIT_W-1:0] : credit;

    state_nxt       = state;
    credit_nxt      = credit;
    disp_req_nxt    = 1'b0;
    change50_nxt    = 1'b0;
    coin_reject_nxt = coin_in && !accept;
    fault_nxt       = fault;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt  = ST_CREDIT;
          credit_nxt = cr_acc;
        end
      end
      ST_CREDIT: begin
        credit_nxt = cr_acc;
        if (credit >= PRICE_C) begin
          state_nxt    = ST_VEND;
          disp_req_nxt = 1'b1;
        end else if (cancel && (credit != '0)) begin
          // Refund starts immediately: the first change pulse is issued on this edge.
          state_nxt    = ST_CHANGE;
          credit_nxt   = cr_acc - 1'b1;
          change50_nxt = 1'b1;
        end
`ifdef VEND_IDLE_TIMEOUT_EN
        else if (timer_expire && !accept) begin
          state_nxt    = ST_CHANGE;
          credit_nxt   = credit - 1'b1;
          change50_nxt = 1'b1;
        end
`endif
      end
      ST_VEND: begin
        disp_req_nxt = 1'b1;
        if (disp_ack) begin
          disp_req_nxt = 1'b0;
          if (credit != PRICE_C) begin
            state_nxt    = ST_CHANGE;
            credit_nxt   = credit - PRICE_C - 1'b1;
            change50_nxt = 1'b1;
          end else begin
            state_nxt  = ST_IDLE;
            credit_nxt = '0;
          end
        end else if (timer_expire) begin
          disp_req_nxt = 1'b0;
          fault_nxt    = 1'b1;
          state_nxt    = ST_CHANGE;
          credit_nxt   = credit - 1'b1;
          change50_nxt = 1'b1;
        end
      end
      ST_CHANGE: begin
        // change50 doubles as the pulse/gap phase; decisions are made in the gap.
        if (!change50) begin
          if (credit == '0) begin
            state_nxt = ST_IDLE;
          end else begin
            change50_nxt = 1'b1;
            credit_nxt   = credit - 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt == ST_VEND) || (state_nxt == ST_CHANGE);

    t_load  = (state_nxt == ST_VEND) && (state != ST_VEND);
    t_val   = TIMER_W'(DISP_TIMEOUT);
    t_clear = (state_nxt != ST_VEND);
`ifdef VEND_IDLE_TIMEOUT_EN
    if (state_nxt == ST_CREDIT) begin
      t_clear = 1'b0;
      if ((state != ST_CREDIT) || accept) begin
        t_load = 1'b1;
        t_val  = TIMER_W'(IDLE_TIMEOUT);
      end
    end
`endif
  end

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed scenarios plus randomized vend/cancel sessions.
module tb_vend_controller;

  localparam int PRICE = 6;
  localparam int MAXU  = 15;
  localparam int DTO   = 1000;
  localparam int ITO   = 20;

  logic clk = 1'b0, reset = 1'b1;
  logic coin50 = 1'b0, coin100 = 1'b0, cancel = 1'b0, disp_ack = 1'b0;
  logic disp_req, change50, coin_reject, busy, fault;
  logic [3:0] credit;

  logic c_coin50 = 1'b0, c_coin100 = 1'b0, c_cancel = 1'b0, c_disp_ack = 1'b0;
  logic c_disp_req, c_change50, c_coin_reject, c_busy, c_fault;
  logic [3:0] c_credit;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vend_controller #(.PRICE_UNITS(PRICE), .MAX_UNITS(MAXU), .DISP_TIMEOUT(DTO), .IDLE_TIMEOUT(ITO)) dut (
    .clk(clk), .reset(reset), .coin50(coin50), .coin100(coin100), .cancel(cancel),
    .disp_ack(disp_ack), .disp_req(disp_req), .change50(change50), .coin_reject(coin_reject),
    .credit(credit), .busy(busy), .fault(fault));

  // Second instance priced at the ceiling so credit can reach 14/15 while still collecting.
  vend_controller #(.PRICE_UNITS(15), .MAX_UNITS(MAXU), .DISP_TIMEOUT(DTO), .IDLE_TIMEOUT(ITO)) u_ceil (
    .clk(clk), .reset(reset), .coin50(c_coin50), .coin100(c_coin100), .cancel(c_cancel),
    .disp_ack(c_disp_ack), .disp_req(c_disp_req), .change50(c_change50), .coin_reject(c_coin_reject),
    .credit(c_credit), .busy(c_busy), .fault(c_fault));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_coin(input logic c50, input logic c100);
    coin50 = c50; coin100 = c100;
    tick();
    coin50 = 1'b0; coin100 = 1'b0;
  endtask

  task automatic pulse_ack();
    disp_ack = 1'b1;
    tick();
    disp_ack = 1'b0;
  endtask

  // Observe until the controller leaves VEND/CHANGE, recording the change pulse pattern.
  task automatic drain(input int budget, output int pulses, output int busy_cyc,
                       output bit alt_ok, output bit req_seen, output bit done);
    logic prev;
    prev = 1'b0; pulses = 0; busy_cyc = 0; alt_ok = 1'b1; req_seen = 1'b0; done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin done = 1'b1; break; end
      busy_cyc++;
      if (change50) begin pulses++; if (prev) alt_ok = 1'b0; end
      if (disp_req) req_seen = 1'b1;
      prev = change50;
      tick();
    end
  endtask

  task automatic watch(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (change50) pulses++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; coin50 = 1'b1; coin100 = 1'b1; cancel = 1'b1; disp_ack = 1'b1;
    repeat (3) tick();
    coin50 = 1'b0; coin100 = 1'b0; cancel = 1'b0; disp_ack = 1'b0;
    total++; if (credit !== 4'd0) begin bad++; $display("FAIL reset_credit: got %0d want 0", credit); end
    total++; if ({disp_req, change50, coin_reject, busy, fault} !== 5'b0) begin
      bad++; $display("FAIL reset_outputs: got %b want 00000", {disp_req, change50, coin_reject, busy, fault}); end
    total++; if ({c_credit, c_busy, c_fault} !== 6'b0) begin
      bad++; $display("FAIL reset_ceil: got %b want 000000", {c_credit, c_busy, c_fault}); end
    reset = 1'b0;
    tick();
    total++; if ({credit, busy, change50} !== 6'b0) begin
      bad++; $display("FAIL reset_release: got %b want 000000", {credit, busy, change50}); end
  endtask

  task automatic test_exact_price();
    int p;
    for (int k = 1; k <= PRICE; k++) begin
      pulse_coin(1'b1, 1'b0);
      total++; if (credit !== 4'(k)) begin bad++; $display("FAIL exact_credit: got %0d want %0d", credit, k); end
      if (k < PRICE) tick();
    end
    total++; if (disp_req !== 1'b0) begin bad++; $display("FAIL exact_req_early: got %b want 0", disp_req); end
    tick();
    total++; if ({disp_req, busy} !== 2'b11) begin bad++; $display("FAIL exact_vend_entry: got %b want 11", {disp_req, busy}); end
    repeat (5) tick();
    total++; if ({disp_req, credit} !== {1'b1, 4'd6}) begin
      bad++; $display("FAIL exact_req_hold: got req=%b credit=%0d want req=1 credit=6", disp_req, credit); end
    pulse_ack();
    total++; if ({disp_req, change50, busy, credit} !== 7'b0) begin
      bad++; $display("FAIL exact_after_ack: got %b want 0000000", {disp_req, change50, busy, credit}); end
    watch(10, p);
    total++; if (p !== 0) begin bad++; $display("FAIL exact_change: got %0d pulses want 0", p); end
  endtask

  task automatic test_overpay();
    int p, bc; bit alt, rq, dn;
    for (int k = 1; k <= 3; k++) begin
      pulse_coin(1'b0, 1'b1);
      total++; if (credit !== 4'(2 * k)) begin bad++; $display("FAIL overpay_credit: got %0d want %0d", credit, 2 * k); end
    end
    pulse_coin(1'b1, 1'b0);
    total++; if ({disp_req, coin_reject, credit} !== {1'b1, 1'b0, 4'd7}) begin
      bad++; $display("FAIL overpay_edge_coin: got req=%b rej=%b credit=%0d want 1 0 7", disp_req, coin_reject, credit); end
    repeat (3) tick();
    pulse_ack();
    total++; if ({disp_req, change50} !== 2'b01) begin
      bad++; $display("FAIL overpay_first_pulse: got %b want 01", {disp_req, change50}); end
    drain(50, p, bc, alt, rq, dn);
    total++; if (!dn || p != 1 || bc != 2 || !alt || credit !== 4'd0) begin
      bad++; $display("FAIL overpay_change: got pulses=%0d busy=%0d alt=%b done=%b credit=%0d want 1 2 1 1 0", p, bc, alt, dn, credit); end
  endtask

  task automatic test_simultaneous();
    int p, bc; bit alt, rq, dn;
    pulse_coin(1'b1, 1'b1);
    total++; if ({credit, coin_reject} !== {4'd3, 1'b0}) begin
      bad++; $display("FAIL simul_credit: got credit=%0d rej=%b want 3 0", credit, coin_reject); end
    cancel = 1'b1; tick(); cancel = 1'b0;
    drain(50, p, bc, alt, rq, dn);
    total++; if (!dn || p != 3 || bc != 6 || !alt || rq) begin
      bad++; $display("FAIL simul_refund: got pulses=%0d busy=%0d alt=%b req=%b want 3 6 1 0", p, bc, alt, rq); end
  endtask

  task automatic test_ceiling();
    for (int k = 0; k < 7; k++) begin
      c_coin100 = 1'b1; tick(); c_coin100 = 1'b0;
    end
    total++; if (c_credit !== 4'd14) begin bad++; $display("FAIL ceil_credit14: got %0d want 14", c_credit); end
    c_coin100 = 1'b1; tick(); c_coin100 = 1'b0;
    total++; if ({c_coin_reject, c_credit} !== {1'b1, 4'd14}) begin
      bad++; $display("FAIL ceil_reject: got rej=%b credit=%0d want 1 14", c_coin_reject, c_credit); end
    c_coin50 = 1'b1; tick(); c_coin50 = 1'b0;
    total++; if ({c_coin_reject, c_credit, c_busy} !== {1'b0, 4'd15, 1'b0}) begin
      bad++; $display("FAIL ceil_accept15: got rej=%b credit=%0d busy=%b want 0 15 0", c_coin_reject, c_credit, c_busy); end
    tick();
    total++; if (c_disp_req !== 1'b1) begin bad++; $display("FAIL ceil_vend: got %b want 1", c_disp_req); end
    c_disp_ack = 1'b1; tick(); c_disp_ack = 1'b0;
    total++; if ({c_credit, c_busy, c_disp_req} !== 6'b0) begin
      bad++; $display("FAIL ceil_after_ack: got %b want 000000", {c_credit, c_busy, c_disp_req}); end
  endtask

  task automatic test_cancel();
    int p, bc; bit alt, rq, dn;
    cancel = 1'b1; tick();
    total++; if ({busy, change50} !== 2'b00) begin bad++; $display("FAIL cancel_idle: got %b want 00", {busy, change50}); end
    cancel = 1'b0;
    pulse_coin(1'b0, 1'b1);
    pulse_coin(1'b0, 1'b1);
    total++; if (credit !== 4'd4) begin bad++; $display("FAIL cancel_credit: got %0d want 4", credit); end
    cancel = 1'b1; tick();
    total++; if ({busy, change50} !== 2'b11) begin bad++; $display("FAIL cancel_first_pulse: got %b want 11", {busy, change50}); end
    drain(50, p, bc, alt, rq, dn);
    total++; if (!dn || p != 4 || bc != 8 || !alt || rq) begin
      bad++; $display("FAIL cancel_refund: got pulses=%0d busy=%0d alt=%b req=%b want 4 8 1 0", p, bc, alt, rq); end
    tick(); cancel = 1'b0;
    total++; if ({busy, change50, credit} !== 6'b0) begin
      bad++; $display("FAIL cancel_held_idle: got %b want 000000", {busy, change50, credit}); end
  endtask

  task automatic test_disp_timeout();
    int p, bc, req_cyc; bit alt, rq, dn;
    repeat (3) pulse_coin(1'b0, 1'b1);
    tick();
    total++; if ({disp_req, fault} !== 2'b10) begin bad++; $display("FAIL timeout_entry: got %b want 10", {disp_req, fault}); end
    req_cyc = 1;
    pulse_coin(1'b1, 1'b0);
    total++; if ({coin_reject, credit} !== {1'b1, 4'd6}) begin
      bad++; $display("FAIL vend_coin_reject: got rej=%b credit=%0d want 1 6", coin_reject, credit); end
    if (disp_req) req_cyc++;
    for (int i = 0; i < DTO + 20 && disp_req; i++) begin
      tick();
      if (disp_req) req_cyc++;
    end
    total++; if (req_cyc != DTO) begin bad++; $display("FAIL timeout_length: got %0d cycles want %0d", req_cyc, DTO); end
    total++; if ({fault, change50, busy} !== 3'b111) begin
      bad++; $display("FAIL timeout_fault: got %b want 111", {fault, change50, busy}); end
    drain(60, p, bc, alt, rq, dn);
    total++; if (!dn || p != 6 || bc != 12 || !alt || fault !== 1'b1) begin
      bad++; $display("FAIL timeout_refund: got pulses=%0d busy=%0d alt=%b fault=%b want 6 12 1 1", p, bc, alt, fault); end
  endtask

  task automatic test_random(input int n);
    int exp, add, d, p, bc, chg; bit alt, rq, dn, mode_cancel, inject;
    for (int s = 0; s < n; s++) begin
      mode_cancel = ($urandom_range(0, 3) == 0);
      exp = 0;
      for (int c = 0; c < 10; c++) begin
        add = $urandom_range(1, 3);
        if (mode_cancel && exp > 0 && exp + add >= PRICE) break;
        pulse_coin(add[0], add[1]);
        exp += add;
        total++; if ({coin_reject, credit} !== {1'b0, 4'(exp)}) begin
          bad++; $display("FAIL rand_coin s=%0d: got rej=%b credit=%0d want 0 %0d", s, coin_reject, credit, exp); end
        if (exp >= PRICE) break;
        repeat ($urandom_range(0, 2)) tick();
      end
      if (exp >= PRICE) begin
        tick();
        d = $urandom_range(0, 20);
        inject = ($urandom_range(0, 1) == 1) && (d > 0);
        for (int i = 0; i < d; i++) begin
          if (i == 0 && inject) begin
            add = $urandom_range(1, 3);
            pulse_coin(add[0], add[1]);
            total++; if ({coin_reject, credit} !== {1'b1, 4'(exp)}) begin
              bad++; $display("FAIL rand_vend_reject s=%0d: got rej=%b credit=%0d want 1 %0d", s, coin_reject, credit, exp); end
          end else tick();
        end
        total++; if (disp_req !== 1'b1) begin bad++; $display("FAIL rand_req s=%0d: got %b want 1", s, disp_req); end
        pulse_ack();
        chg = exp - PRICE;
        total++; if ({disp_req, change50} !== {1'b0, chg > 0}) begin
          bad++; $display("FAIL rand_ack s=%0d: got %b want 0%b", s, {disp_req, change50}, chg > 0); end
        drain(60, p, bc, alt, rq, dn);
        total++; if (!dn || p != chg || bc != 2 * chg || !alt || credit !== 4'd0 || fault !== 1'b1) begin
          bad++; $display("FAIL rand_change s=%0d: got pulses=%0d busy=%0d alt=%b credit=%0d fault=%b want %0d %0d 1 0 1",
                          s, p, bc, alt, credit, fault, chg, 2 * chg); end
      end else begin
        cancel = 1'b1; tick(); cancel = 1'b0;
        drain(60, p, bc, alt, rq, dn);
        total++; if (!dn || p != exp || bc != 2 * exp || !alt || rq || credit !== 4'd0) begin
          bad++; $display("FAIL rand_cancel s=%0d: got pulses=%0d busy=%0d alt=%b req=%b credit=%0d want %0d %0d 1 0 0",
                          s, p, bc, alt, rq, credit, exp, 2 * exp); end
      end
    end
  endtask

  task automatic test_reset_mid_change();
    int p;
    pulse_coin(1'b1, 1'b1);
    cancel = 1'b1; tick(); cancel = 1'b0;
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midreset_setup: got busy=%b want 1", busy); end
    reset = 1'b1; tick(); reset = 1'b0;
    total++; if ({disp_req, change50, coin_reject, busy, fault, credit} !== 9'b0) begin
      bad++; $display("FAIL midreset_outputs: got %b want 000000000", {disp_req, change50, coin_reject, busy, fault, credit}); end
    watch(6, p);
    total++; if (p != 0 || busy !== 1'b0) begin bad++; $display("FAIL midreset_no_refund: got pulses=%0d busy=%b want 0 0", p, busy); end
  endtask

  task automatic test_idle_timeout();
    int p, bc, k; bit alt, rq, dn;
    pulse_coin(1'b0, 1'b1);
    total++; if (credit !== 4'd2) begin bad++; $display("FAIL idle_credit: got %0d want 2", credit); end
`ifdef VEND_IDLE_TIMEOUT_EN
    k = 0;
    for (int i = 0; i < 5 * ITO && !change50; i++) begin tick(); k++; end
    total++; if (k != ITO) begin bad++; $display("FAIL idle_timeout_delay: got %0d cycles want %0d", k, ITO); end
`else
    watch(3 * ITO, p);
    total++; if (p != 0 || credit !== 4'd2 || busy !== 1'b0) begin
      bad++; $display("FAIL idle_wait: got pulses=%0d credit=%0d busy=%b want 0 2 0", p, credit, busy); end
    cancel = 1'b1; tick(); cancel = 1'b0;
`endif
    drain(40, p, bc, alt, rq, dn);
    total++; if (!dn || p != 2 || bc != 4 || !alt || fault !== 1'b0) begin
      bad++; $display("FAIL idle_refund: got pulses=%0d busy=%0d alt=%b fault=%b want 2 4 1 0", p, bc, alt, fault); end
  endtask

  initial begin
    test_reset();
    test_exact_price();
    test_overpay();
    test_simultaneous();
    test_ceiling();
    test_cancel();
    test_disp_timeout();
    test_random(20);
    test_reset_mid_change();
    test_idle_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
